pico_bus_arbiter: RTL and testbench
===================================

// Module: pico_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32b PicoBus slave port (e.g. the test counter at
//  0x101xxxxx, free-run control at 0x100000A0) among NUM_REQ local requesters.
//  One transaction in flight. Each grant becomes a single-cycle PicoRd/PicoWr strobe.
//  Read data is captured RD_LATENCY cycles after the strobe and returned to the winner.
// PARAMETERS
//  NUM_REQ     4  number of requesters, 2..8
//  RD_LATENCY  1  cycles from PicoRd strobe cycle to the cycle PicoDataOut is valid, 1..15
// PORTS
//  PicoClk      in   1           clock
//  PicoRst      in   1           synchronous reset, active-high
//  ReqValid     in   NUM_REQ     request pending, one bit per requester
//  ReqWrite     in   NUM_REQ     1 = write, 0 = read, per requester
//  ReqAddr      in   32*NUM_REQ  address; requester i drives [32*i+:32]
//  ReqData      in   32*NUM_REQ  write data; requester i drives [32*i+:32]
//  ReqReady     out  NUM_REQ     one-hot accept pulse; combinational, IDLE only
//  RespValid    out  NUM_REQ     one-hot completion pulse; registered
//  RespData     out  32          read data, valid with RespValid; 0 for write acks
//  Busy         out  1           state != IDLE
//  PicoAddr     out  32          slave address; registered
//  PicoDataIn   out  32          slave write data; registered
//  PicoRd       out  1           read strobe; registered
//  PicoWr       out  1           write strobe; registered
//  PicoDataOut  in   32          slave read data (0 when slave not selected)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; round-robin pointer Last = NUM_REQ-1.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE, cycle T:
//   - Search ReqValid from index Last+1 upward, wrapping mod NUM_REQ; first set bit wins (W).
//   - ReqReady[W]=1 in cycle T only; latch Addr/Data/Write of W; Last<=W; go ISSUE.
//   - No ReqValid set: stay IDLE.
//  ISSUE, cycle T+1:
//   - PicoRd or PicoWr =1 for exactly this cycle.
//   - PicoAddr/PicoDataIn carry the latched values; read -> WAIT, write -> RESP.
//  WAIT:
//   - Down-counter loaded with RD_LATENCY; strobes 0.
//   - In cycle T+1+RD_LATENCY, capture PicoDataOut into RespData; go RESP.
//  RESP:
//   - RespValid[W]=1 for one cycle: read at T+2+RD_LATENCY, write at T+2.
//   - RespData = captured data (read) or 0 (write); next cycle IDLE.
//  Outside ISSUE, PicoAddr/PicoDataIn/PicoRd/PicoWr are 0, so no slave decodes a stray access.
//  Occupancy: read RD_LATENCY+3 cycles, write 3 cycles. No pipelining; arbitration only in IDLE.
//  Request protocol:
//   - ReqValid and its fields are held until ReqReady; a requester may re-request after its RespValid.
//   - ReqValid dropped before grant: no effect; it was never sampled.
//   - ReqValid/fields changed while Busy: ignored; the latched copy is used.
//  Fairness: with all requesters asserted, grants rotate 0,1,..,NUM_REQ-1,0; none waits > NUM_REQ grants.
//  Simultaneous new requests and RESP: new requests are granted in the following IDLE cycle.
//  Reset mid-operation:
//   - In-flight transaction is abandoned; no RespValid is issued.
//   - All strobes drop the cycle after PicoRst is sampled.
//  RespData holds its value between responses; only qualified by RespValid.
// TESTING
//  Write: reset, req1 write 0x10100000 data 5 (counter adds 5) -> PicoWr 1 cycle at T+1 with
//   PicoDataIn=5; RespValid=0010 at T+2 with RespData=0.
//  Read: then req0 read 0x10100000 -> PicoRd 1 cycle; RespValid=0001 at T+3 with RespData=5.
//   Second read returns 6 (counter increments on each read).
//  Round-robin: ReqValid=1111 held, all reads -> grant order 0,1,2,3,0.
//   Each read spans RD_LATENCY+3 cycles; no grant while Busy.
//  Pointer: after grant to 2, ReqValid=0101 -> grant 0, then 2.
//   After grant to 3, ReqValid=1001 -> grant 0 (wrap).
//  Reset in WAIT: assert PicoRst for 1 cycle -> no RespValid.
//   Outputs 0; next request with ReqValid=1111 goes to req0.
//  Free-run: req3 writes 0x100000A0 data 1, then req0 reads the counter twice ->
//   second value - first value = read spacing in cycles (RD_LATENCY+3 with no other requesters).

Source files
------------

// File: rtl/pico_bus_arbiter.sv
// pico_bus_arbiter
// Round-robin arbiter that shares one 32-bit PicoBus slave port among NUM_REQ
// local requesters. One transaction is in flight at a time: a grant becomes a
// single-cycle PicoRd/PicoWr strobe, and the read data returns to the winner
// RD_LATENCY cycles after the strobe.
module pico_bus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  PicoClk,
    input  logic                  PicoRst,
    input  logic [NUM_REQ-1:0]    ReqValid,
    input  logic [NUM_REQ-1:0]    ReqWrite,
    input  logic [32*NUM_REQ-1:0] ReqAddr,
    input  logic [32*NUM_REQ-1:0] ReqData,
    output logic [NUM_REQ-1:0]    ReqReady,
    output logic [NUM_REQ-1:0]    RespValid,
    output logic [31:0]           RespData,
    output logic                  Busy,
    output logic [31:0]           PicoAddr,
    output logic [31:0]           PicoDataIn,
    output logic                  PicoRd,
    output logic                  PicoWr,
    input  logic [31:0]           PicoDataOut
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_win;
    logic                 r_write;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [31:0]          r_resp_data;
    logic [31:0]          r_pico_addr;
    logic [31:0]          r_pico_data_in;
    logic                 r_pico_rd;
    logic                 r_pico_wr;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic                 w_sel_write;
    logic [31:0]          w_sel_addr;
    logic [31:0]          w_sel_data;
    int unsigned          w_idx;

    // Round-robin search starting one past the last winner, wrapping mod NUM_REQ;
    // the winner's request fields are selected in the same pass.
    always_comb begin
        w_found     = 1'b0;
        w_win       = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(r_last) + k) % NUM_REQ;
            if (!w_found && ReqValid[IDX_W'(w_idx)]) begin
                w_found     = 1'b1;
                w_win       = IDX_W'(w_idx);
                w_sel_write = ReqWrite[IDX_W'(w_idx)];
                w_sel_addr  = ReqAddr[32*w_idx +: 32];
                w_sel_data  = ReqData[32*w_idx +: 32];
            end
        end
    end

    // One-hot decode of the current search result and of the latched winner.
    always_comb begin
        w_grant      = '0;
        w_win_onehot = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
        w_win_onehot[r_win] = 1'b1;
    end

    // Accept pulse exists only in IDLE; suppressed while reset is asserted so a
    // requester never sees an accept that the FSM does not take.
    always_comb begin
        ReqReady = '0;
        if (r_state == ST_IDLE && !PicoRst) begin
            ReqReady = w_grant;
        end
    end

    // Transaction FSM with registered bus strobes, address/data and responses.
    always_ff @(posedge PicoClk) begin
        if (PicoRst) begin
            r_state        <= ST_IDLE;
            r_last         <= IDX_W'(NUM_REQ - 1);
            r_win          <= '0;
            r_write        <= 1'b0;
            r_cnt          <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= '0;
            r_pico_addr    <= '0;
            r_pico_data_in <= '0;
            r_pico_rd      <= 1'b0;
            r_pico_wr      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_win          <= w_win;
                        r_last         <= w_win;
                        r_write        <= w_sel_write;
                        r_pico_addr    <= w_sel_addr;
                        r_pico_data_in <= w_sel_data;
                        r_pico_rd      <= !w_sel_write;
                        r_pico_wr      <= w_sel_write;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Bus outputs are only non-zero during ISSUE.
                    r_pico_addr    <= '0;
                    r_pico_data_in <= '0;
                    r_pico_rd      <= 1'b0;
                    r_pico_wr      <= 1'b0;
                    if (r_write) begin
                        r_resp_valid <= w_win_onehot;
                        r_resp_data  <= '0;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt   <= CNT_W'(RD_LATENCY);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_resp_data  <= PicoDataOut;
                        r_resp_valid <= w_win_onehot;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= '0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy       = (r_state != ST_IDLE);
    assign RespValid  = r_resp_valid;
    assign RespData   = r_resp_data;
    assign PicoAddr   = r_pico_addr;
    assign PicoDataIn = r_pico_data_in;
    assign PicoRd     = r_pico_rd;
    assign PicoWr     = r_pico_wr;

endmodule

// File: tb/tb_pico_bus_arbiter.sv
// tb_pico_bus_arbiter
// Directed bench for pico_bus_arbiter with a small PicoBus slave model: a test
// counter at 0x101xxxxx (write adds, read returns then increments) and a
// free-run control register at 0x100000A0 (bit 0 makes the counter tick every cycle).
module tb_pico_bus_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned LAT   = 1;
    localparam int          BOUND = 50;

    logic                 PicoClk = 1'b0;
    logic                 PicoRst;
    logic [NR-1:0]        ReqValid;
    logic [NR-1:0]        ReqWrite;
    logic [32*NR-1:0]     ReqAddr;
    logic [32*NR-1:0]     ReqData;
    logic [NR-1:0]        ReqReady;
    logic [NR-1:0]        RespValid;
    logic [31:0]          RespData;
    logic                 Busy;
    logic [31:0]          PicoAddr;
    logic [31:0]          PicoDataIn;
    logic                 PicoRd;
    logic                 PicoWr;
    logic [31:0]          PicoDataOut;

    int n_cmp = 0;
    int n_err = 0;

    pico_bus_arbiter #(
        .NUM_REQ    (NR),
        .RD_LATENCY (LAT)
    ) dut (
        .PicoClk     (PicoClk),
        .PicoRst     (PicoRst),
        .ReqValid    (ReqValid),
        .ReqWrite    (ReqWrite),
        .ReqAddr     (ReqAddr),
        .ReqData     (ReqData),
        .ReqReady    (ReqReady),
        .RespValid   (RespValid),
        .RespData    (RespData),
        .Busy        (Busy),
        .PicoAddr    (PicoAddr),
        .PicoDataIn  (PicoDataIn),
        .PicoRd      (PicoRd),
        .PicoWr      (PicoWr),
        .PicoDataOut (PicoDataOut)
    );

    always #5 PicoClk = ~PicoClk;

    // Slave model
    logic [31:0] slave_cnt  = 32'd0;
    logic        slave_free = 1'b0;
    logic [31:0] rd_pipe [1:LAT];
    logic        cnt_hit;

    initial begin
        for (int k = 1; k <= int'(LAT); k++) rd_pipe[k] = 32'd0;
    end

    assign cnt_hit     = (PicoAddr[31:20] == 12'h101);
    assign PicoDataOut = rd_pipe[1];

    always @(posedge PicoClk) begin
        for (int k = 1; k < int'(LAT); k++) rd_pipe[k] <= rd_pipe[k+1];
        rd_pipe[LAT] <= (PicoRd && cnt_hit) ? slave_cnt : 32'd0;
        if (slave_free)
            slave_cnt <= slave_cnt + 32'd1;
        else if (PicoWr && cnt_hit)
            slave_cnt <= slave_cnt + PicoDataIn;
        else if (PicoRd && cnt_hit)
            slave_cnt <= slave_cnt + 32'd1;
        if (PicoWr && PicoAddr == 32'h100000A0)
            slave_free <= PicoDataIn[0];
    end

    // Stimulus helpers (no checking)
    task automatic set_req(input int unsigned idx, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        ReqWrite[idx]        = wr;
        ReqAddr[32*idx +: 32] = a;
        ReqData[32*idx +: 32] = d;
    endtask

    task automatic apply_reset();
        @(negedge PicoClk);
        PicoRst  = 1'b1;
        ReqValid = '0;
        @(negedge PicoClk);
        PicoRst  = 1'b0;
    endtask

    // Returns the first non-zero ReqReady seen, starting in the current cycle;
    // g stays 0 if the bound expires.
    task automatic wait_grant(output logic [NR-1:0] g, output int cyc);
        g = '0;
        for (cyc = 0; cyc < BOUND; cyc++) begin
            #1;
            if (ReqReady != '0) begin
                g = ReqReady;
                return;
            end
            @(negedge PicoClk);
        end
    endtask

    task automatic wait_resp(output logic [NR-1:0] v, output logic [31:0] d);
        v = '0;
        d = '0;
        for (int cyc = 0; cyc < BOUND; cyc++) begin
            #1;
            if (RespValid != '0) begin
                v = RespValid;
                d = RespData;
                return;
            end
            @(negedge PicoClk);
        end
    endtask

    task automatic test_reset();
        PicoRst  = 1'b1;
        ReqValid = 4'b1111;
        repeat (2) @(negedge PicoClk);
        #1;
        n_cmp++; if (ReqReady !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", ReqReady); end
        n_cmp++; if (RespValid !== 4'b0000) begin n_err++; $display("FAIL reset_respvalid: got %b want 0000", RespValid); end
        n_cmp++; if (RespData !== 32'd0) begin n_err++; $display("FAIL reset_respdata: got %0h want 0", RespData); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (PicoAddr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", PicoAddr); end
        n_cmp++; if (PicoDataIn !== 32'd0) begin n_err++; $display("FAIL reset_datain: got %0h want 0", PicoDataIn); end
        n_cmp++; if ({PicoRd, PicoWr} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {PicoRd, PicoWr}); end
        ReqValid = '0;
        PicoRst  = 1'b0;
        @(negedge PicoClk);
    endtask

    task automatic test_write();
        logic [NR-1:0] g;
        int            cyc;
        set_req(1, 1'b1, 32'h10100000, 32'd5);
        ReqValid = 4'b0010;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL wr_grant: got %b want 0010", g); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_idle: got %b want 0", Busy); end
        @(negedge PicoClk);
        ReqValid = '0;
        // fields change while busy: the latched copy must be used
        set_req(1, 1'b0, 32'hDEAD0000, 32'hDEADBEEF);
        #1;
        n_cmp++; if ({PicoWr, PicoRd} !== 2'b10) begin n_err++; $display("FAIL wr_strobe: got %b want 10", {PicoWr, PicoRd}); end
        n_cmp++; if (PicoAddr !== 32'h10100000) begin n_err++; $display("FAIL wr_addr: got %0h want 10100000", PicoAddr); end
        n_cmp++; if (PicoDataIn !== 32'd5) begin n_err++; $display("FAIL wr_datain: got %0h want 5", PicoDataIn); end
        n_cmp++; if (ReqReady !== 4'b0000) begin n_err++; $display("FAIL wr_ready_busy: got %b want 0000", ReqReady); end
        @(negedge PicoClk);
        #1;
        n_cmp++; if (RespValid !== 4'b0010) begin n_err++; $display("FAIL wr_respvalid: got %b want 0010", RespValid); end
        n_cmp++; if (RespData !== 32'd0) begin n_err++; $display("FAIL wr_respdata: got %0h want 0", RespData); end
        n_cmp++; if ({PicoWr, PicoAddr} !== 33'd0) begin n_err++; $display("FAIL wr_bus_quiet: got %0h want 0", {PicoWr, PicoAddr}); end
        @(negedge PicoClk);
        #1;
        n_cmp++; if ({RespValid, Busy} !== 5'b00000) begin n_err++; $display("FAIL wr_done: got %b want 00000", {RespValid, Busy}); end
    endtask

    task automatic test_read();
        logic [NR-1:0] g;
        int            cyc;
        for (int n = 0; n < 2; n++) begin
            set_req(0, 1'b0, 32'h10100000, 32'd0);
            ReqValid = 4'b0001;
            wait_grant(g, cyc);
            n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL rd%0d_grant: got %b want 0001", n, g); end
            @(negedge PicoClk);
            ReqValid = '0;
            #1;
            n_cmp++; if ({PicoRd, PicoWr} !== 2'b10) begin n_err++; $display("FAIL rd%0d_strobe: got %b want 10", n, {PicoRd, PicoWr}); end
            n_cmp++; if (PicoAddr !== 32'h10100000) begin n_err++; $display("FAIL rd%0d_addr: got %0h want 10100000", n, PicoAddr); end
            for (int k = 0; k < int'(LAT); k++) begin
                @(negedge PicoClk);
                #1;
                n_cmp++; if ({RespValid, PicoRd} !== 5'b00000) begin n_err++; $display("FAIL rd%0d_wait: got %b want 00000", n, {RespValid, PicoRd}); end
            end
            @(negedge PicoClk);
            #1;
            n_cmp++; if (RespValid !== 4'b0001) begin n_err++; $display("FAIL rd%0d_respvalid: got %b want 0001", n, RespValid); end
            n_cmp++; if (RespData !== 32'd5 + 32'(n)) begin n_err++; $display("FAIL rd%0d_respdata: got %0d want %0d", n, RespData, 5 + n); end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        logic [NR-1:0] exp_g;
        int            cyc;
        apply_reset();
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b0, 32'h20000000, 32'd0);
        ReqValid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, cyc);
            exp_g = 4'b0001 << (i % 4);
            n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, g, exp_g); end
            if (i > 0) begin
                n_cmp++; if (cyc + 1 !== int'(LAT) + 3) begin n_err++; $display("FAIL rr_spacing%0d: got %0d want %0d", i, cyc + 1, LAT + 3); end
            end
            @(negedge PicoClk);
        end
        ReqValid = '0;
    endtask

    task automatic test_pointer();
        logic [NR-1:0] g;
        int            cyc;
        apply_reset();
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, 32'h30000000, 32'd0);
        ReqValid = 4'b0100;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL ptr_first: got %b want 0100", g); end
        @(negedge PicoClk);
        ReqValid = 4'b0101;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL ptr_after2_a: got %b want 0001", g); end
        @(negedge PicoClk);
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL ptr_after2_b: got %b want 0100", g); end
        @(negedge PicoClk);
        ReqValid = 4'b1000;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL ptr_grant3: got %b want 1000", g); end
        @(negedge PicoClk);
        ReqValid = 4'b1001;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL ptr_wrap: got %b want 0001", g); end
        @(negedge PicoClk);
        ReqValid = '0;
    endtask

    task automatic test_reset_in_wait();
        logic [NR-1:0] g;
        int            cyc;
        apply_reset();
        for (int i = 0; i < int'(NR); i++) set_req(i, 1'b0, 32'h20000000, 32'd0);
        set_req(0, 1'b0, 32'h10100000, 32'd0);
        ReqValid = 4'b0001;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL rst_pre_grant: got %b want 0001", g); end
        @(negedge PicoClk);
        ReqValid = '0;
        repeat (LAT) @(negedge PicoClk);
        #1;
        n_cmp++; if ({Busy, RespValid} !== 5'b10000) begin n_err++; $display("FAIL rst_in_wait: got %b want 10000", {Busy, RespValid}); end
        PicoRst = 1'b1;
        @(negedge PicoClk);
        PicoRst = 1'b0;
        #1;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", Busy); end
        n_cmp++; if ({PicoRd, PicoWr, PicoAddr, PicoDataIn} !== 66'd0) begin n_err++; $display("FAIL rst_bus: got %0h want 0", {PicoRd, PicoWr, PicoAddr, PicoDataIn}); end
        n_cmp++; if (RespData !== 32'd0) begin n_err++; $display("FAIL rst_respdata: got %0h want 0", RespData); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (RespValid !== 4'b0000) begin n_err++; $display("FAIL rst_no_resp%0d: got %b want 0000", k, RespValid); end
            @(negedge PicoClk);
            #1;
        end
        ReqValid = 4'b1111;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL rst_next_grant: got %b want 0001", g); end
        @(negedge PicoClk);
        ReqValid = '0;
    endtask

    task automatic test_free_run();
        logic [NR-1:0] g;
        logic [NR-1:0] v;
        logic [31:0]   d1;
        logic [31:0]   d2;
        int            cyc;
        apply_reset();
        set_req(3, 1'b1, 32'h100000A0, 32'd1);
        ReqValid = 4'b1000;
        wait_grant(g, cyc);
        n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL fr_wr_grant: got %b want 1000", g); end
        @(negedge PicoClk);
        set_req(0, 1'b0, 32'h10100000, 32'd0);
        ReqValid = 4'b0001;
        wait_resp(v, d1);
        n_cmp++; if (v !== 4'b1000) begin n_err++; $display("FAIL fr_wr_ack: got %b want 1000", v); end
        @(negedge PicoClk);
        wait_resp(v, d1);
        n_cmp++; if (v !== 4'b0001) begin n_err++; $display("FAIL fr_rd1_valid: got %b want 0001", v); end
        @(negedge PicoClk);
        wait_resp(v, d2);
        ReqValid = '0;
        n_cmp++; if (v !== 4'b0001) begin n_err++; $display("FAIL fr_rd2_valid: got %b want 0001", v); end
        n_cmp++; if (d2 - d1 !== 32'(LAT + 3)) begin n_err++; $display("FAIL fr_delta: got %0d want %0d", d2 - d1, LAT + 3); end
        repeat (3) @(negedge PicoClk);
    endtask

    initial begin
        PicoRst  = 1'b1;
        ReqValid = '0;
        ReqWrite = '0;
        ReqAddr  = '0;
        ReqData  = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_pointer();
        test_reset_in_wait();
        test_free_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
